// File: rtl/qos_way_arbiter.sv
// qos_way_arbiter: grants one shared downstream port to one of SLV_NUM ways.
// Priority is round-robin from a rotating pointer (qos_en=0), or highest
// eligible QoS with round-robin tie-break (qos_en=1). Each grant is held
// until last or a requester abort, and is followed by one dead IDLE cycle.
// Optional starvation guard: define QOS_ARB_STARVE_GUARD_EN to add per-way
// age counters; a way that has waited AGE_LIMIT cycles outranks any QoS.
module qos_way_arbiter #(
  parameter int SLV_NUM   = 3,
  parameter int ID_WIDTH  = 2,
  parameter int QOS_WIDTH = 2,
  parameter int AGE_LIMIT = 15
) (
  input  logic                           pclk,
  input  logic                           rst_b,
  input  logic [SLV_NUM-1:0]             way_en,
  input  logic                           qos_en,
  input  logic [SLV_NUM-1:0]             req,
  input  logic [SLV_NUM*QOS_WIDTH-1:0]   qos,
  input  logic                           last,
  output logic [SLV_NUM-1:0]             gnt,
  output logic [ID_WIDTH-1:0]            gnt_id,
  output logic                           gnt_vld,
  output logic                           busy
);

  // One extra priority bit so an aged way can sit above every QoS value.
  localparam int PW = QOS_WIDTH + 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q;
  logic [SLV_NUM-1:0]    gnt_q;
  logic [ID_WIDTH-1:0]   gnt_id_q;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic                  vld_q;

  logic [SLV_NUM-1:0]    elig;
  logic [PW-1:0]         pri [SLV_NUM];
  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  logic                  rel;
  logic [ID_WIDTH-1:0]   ptr_nxt;

`ifdef QOS_ARB_STARVE_GUARD_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0]      age_q [SLV_NUM];
`endif

  assign elig = req & way_en;

  // Effective priority per way: QoS (or flat 0 in round-robin mode), aged ways on top.
  always_comb begin
    for (int i = 0; i < SLV_NUM; i++) begin
      pri[i] = '0;
      if (qos_en) pri[i] = {1'b0, qos[i*QOS_WIDTH +: QOS_WIDTH]};
`ifdef QOS_ARB_STARVE_GUARD_EN
      if (age_q[i] == AGE_W'(AGE_LIMIT)) pri[i] = PW'(1) << QOS_WIDTH;
`endif
    end
  end

  // Walk ways in round-robin order from ptr; strictly-greater keeps the
  // earliest way in that order among equal top priorities.
  always_comb begin
    logic [PW-1:0]       best;
    logic [ID_WIDTH-1:0] sel;
    int                  idx;
    win_found = 1'b0;
    win_id    = '0;
    best      = '0;
    sel       = '0;
    idx       = 0;
    for (int k = 0; k < SLV_NUM; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= SLV_NUM) idx = idx - SLV_NUM;
      sel = ID_WIDTH'(idx);
      if (elig[sel] && (!win_found || pri[sel] > best)) begin
        win_found = 1'b1;
        win_id    = sel;
        best      = pri[sel];
      end
    end
  end

  // Release on final beat or when the granted requester withdraws.
  assign rel     = last || !req[gnt_id_q];
  assign ptr_nxt = (gnt_id_q == ID_WIDTH'(SLV_NUM - 1)) ? '0 : gnt_id_q + 1'b1;

  // Grant FSM with registered outputs; pointer moves only on release.
  always_ff @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      vld_q    <= 1'b0;
      ptr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q  <= GRANT;
            gnt_q    <= SLV_NUM'(1) << win_id;
            gnt_id_q <= win_id;
            vld_q    <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            vld_q    <= 1'b0;
            ptr_q    <= ptr_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef QOS_ARB_STARVE_GUARD_EN
  // Age each waiting way; clear on grant or loss of eligibility, saturate at the limit.
  always_ff @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < SLV_NUM; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < SLV_NUM; i++) begin
        if (!elig[i] || gnt_q[i] ||
            (state_q == IDLE && win_found && win_id == ID_WIDTH'(i)))
          age_q[i] <= '0;
        else if (age_q[i] != AGE_W'(AGE_LIMIT))
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end
`endif

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = vld_q;
  assign busy    = (state_q == GRANT);

endmodule

// File: doc/qos_way_arbiter.md
Name: qos_way_arbiter

Overview:
Shares one downstream port between SLV_NUM requesters ("ways") and issues one grant at a time. Eligibility comes from the way_en vector. Priority is plain round-robin when qos_en=0, or QoS-value-first with round-robin tie-break when qos_en=1. Both way_en and qos_en are driven by the APB configuration register block, and this block sits between the requesters and the shared port.

Parameters:
SLV_NUM, 3, number of requesters/ways
ID_WIDTH, 2, width of grant index; must satisfy 2^ID_WIDTH >= SLV_NUM
QOS_WIDTH, 2, per-requester QoS priority width; higher value = higher priority
AGE_LIMIT, 15, wait-cycle threshold for starvation guard (optional feature only)

Ports:
pclk  input  1  clock; all logic on rising edge
rst_b  input  1  asynchronous active-low reset
way_en  input  SLV_NUM  per-way enable; 0 masks that requester
qos_en  input  1  1 = QoS arbitration, 0 = pure round-robin
req  input  SLV_NUM  request, held high until granted transfer ends
qos  input  SLV_NUM*QOS_WIDTH  packed QoS values; way i at [i*QOS_WIDTH +: QOS_WIDTH]
last  input  1  final beat of current granted transfer
gnt  output  SLV_NUM  one-hot grant, registered
gnt_id  output  ID_WIDTH  binary index of granted way, registered
gnt_vld  output  1  grant active, registered
busy  output  1  high in GRANT state

Behaviour:
- Reset (async, rst_b=0):
  - gnt=0, gnt_id=0, gnt_vld=0, busy=0
  - state=IDLE, rr pointer=0, age counters=0
- Eligible set: elig = req & way_en.
- FSM states: IDLE, GRANT.
- IDLE:
  - If elig!=0, select winner combinationally.
  - On the next edge: gnt[w]=1, gnt_id=w, gnt_vld=1, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - If elig==0, stay in IDLE with outputs 0.
- Round-robin selection:
  - Search from index ptr upward, wrapping modulo SLV_NUM; first eligible way wins.
- QoS selection (qos_en=1):
  - Find the max qos among eligible ways.
  - Among ways equal to that max, apply round-robin from ptr.
  - qos values of ineligible ways are ignored.
- GRANT:
  - Hold gnt/gnt_id constant.
  - Release when last=1, or when req[gnt_id]=0 (requester abort).
  - On release edge: gnt=0, gnt_vld=0, ptr=(gnt_id+1) wrapping to 0 past SLV_NUM-1, state=IDLE.
  - One dead cycle always separates consecutive grants.
- way_en or qos_en changes during GRANT do not revoke the current grant. They take effect at the next IDLE arbitration.
- last while in IDLE is ignored.
- last and req drop in the same cycle count as a single release.
- Pointer updates only on release, never on a masked or idle cycle.
- rst_b asserted mid-GRANT: immediate return to reset values. No pending grant survives.
- gnt is always one-hot or zero. gnt_vld == |gnt. busy == (state==GRANT).

Optional Feature:
Macro: QOS_ARB_STARVE_GUARD_EN.
- Defined:
  - Per-way age counter of width clog2(AGE_LIMIT+1).
  - Counter increments each cycle the way is eligible but not granted, and saturates at AGE_LIMIT.
  - Counter clears when the way is granted or becomes ineligible.
  - A way whose age == AGE_LIMIT is treated as QoS all-ones plus one (above any qos value), in both qos_en modes.
  - Multiple aged ways are resolved by round-robin.
- Undefined: no counters; selection exactly as above.

Test Plan:
- Reset check: rst_b=0 with req=3'b111 -> gnt=0, gnt_vld=0, busy=0. Release reset, qos_en=0, way_en=3'b111, req=3'b111 -> cycle 1 gnt=001; last -> next gnt 010, then 100, then 001 (one dead cycle between each).
- Masking: way_en=3'b101, req=3'b111 -> way 1 never granted; grants alternate 001, 100.
- QoS mode: qos_en=1, way_en=3'b111, req=3'b111, qos={2'd1,2'd3,2'd3} (way2..0) -> grants alternate way0, way1; way2 is not granted while ways 0/1 keep requesting.
- Abort: way 1 granted, req[1] drops with last=0 -> gnt=0 next cycle, ptr=2; way_en cleared mid-grant -> grant held until last.
- Async reset mid-GRANT: assert rst_b between edges during a grant -> gnt=0, busy=0 immediately; after release, arbitration restarts from ptr=0.
- With QOS_ARB_STARVE_GUARD_EN, AGE_LIMIT=15, qos_en=1, way2 qos=0, ways 0/1 qos=3 issuing single-beat transfers -> way2 granted once its age counter reaches 15.
